// File: rtl/calendar_ctr.sv
// calendar_ctr: date / month / day-of-week counter feeding the LCD interface.
// Run mode advances once per DayTick with month-length aware carries; set mode
// lets pushbutton rising edges step each field independently.
module calendar_ctr #(
  parameter int FEB_DAYS = 28
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       DayTick,
  input  logic       SetMode,
  input  logic       DateAdv,
  input  logic       MonthAdv,
  input  logic       DayAdv,
  output logic [5:0] date_out,
  output logic [4:0] month_out,
  output logic [2:0] day_out,
  output logic       month_tick,
  output logic       year_tick
);

  // Registered calendar fields grouped so next-state logic reads as one unit.
  typedef struct packed {
    logic [5:0] date;
    logic [4:0] month;
    logic [2:0] day;
  } cal_t;

  localparam cal_t CAL_RST = '{date: 6'd1, month: 5'd1, day: 3'd0};

  // Bit order of the button vectors: [0]=date, [1]=month, [2]=day.
  localparam int B_DATE  = 0;
  localparam int B_MONTH = 1;
  localparam int B_DAY   = 2;

  // Last date of a month; February length is fixed at elaboration.
  function automatic logic [5:0] month_last(input logic [4:0] m);
    case (m)
      5'd2:                    month_last = 6'(FEB_DAYS);
      5'd4, 5'd6, 5'd9, 5'd11: month_last = 6'd30;
      default:                 month_last = 6'd31;
    endcase
  endfunction

  cal_t       cal_q, cal_nxt;
  logic       mt_nxt, yt_nxt;
  logic [2:0] btn, btn_prev, btn_edge;

  logic [5:0] last_cur, last_new, date_inc;
  logic [4:0] month_inc;
  logic [2:0] day_inc;
  logic       date_wrap;

  assign btn      = {DayAdv, MonthAdv, DateAdv};
  assign btn_edge = btn & ~btn_prev;

  // Wrap comparisons use >= so any corrupted value still steers back in range.
  assign last_cur  = month_last(cal_q.month);
  assign date_wrap = (cal_q.date >= last_cur);
  assign date_inc  = date_wrap ? 6'd1 : cal_q.date + 6'd1;
  assign month_inc = (cal_q.month >= 5'd12) ? 5'd1 : cal_q.month + 5'd1;
  assign day_inc   = (cal_q.day >= 3'd6) ? 3'd0 : cal_q.day + 3'd1;
  assign last_new  = month_last(month_inc);

  // Next-state selection: set-mode button edges, or run-mode day rollover.
  always_comb begin
    cal_nxt = cal_q;
    mt_nxt  = 1'b0;
    yt_nxt  = 1'b0;
    if (SetMode) begin
      // Date steps against the old month first; the clamp then uses the new month.
      if (btn_edge[B_DATE])  cal_nxt.date = date_inc;
      if (btn_edge[B_DAY])   cal_nxt.day  = day_inc;
      if (btn_edge[B_MONTH]) begin
        cal_nxt.month = month_inc;
        if (cal_nxt.date > last_new) cal_nxt.date = last_new;
      end
    end else if (DayTick) begin
      cal_nxt.day  = day_inc;
      cal_nxt.date = date_inc;
      if (date_wrap) begin
        cal_nxt.month = month_inc;
        mt_nxt        = 1'b1;
        yt_nxt        = (cal_q.month >= 5'd12);
      end
    end
  end

  // Calendar state and tick pulses; ticks align with the first cycle of new values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cal_q      <= CAL_RST;
      month_tick <= 1'b0;
      year_tick  <= 1'b0;
    end else begin
      cal_q      <= cal_nxt;
      month_tick <= mt_nxt;
      year_tick  <= yt_nxt;
    end
  end

  // Button history tracks every cycle so a button held across a mode switch never fires.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) btn_prev <= 3'b000;
    else          btn_prev <= btn;
  end

  assign date_out  = cal_q.date;
  assign month_out = cal_q.month;
  assign day_out   = cal_q.day;

endmodule

// File: tb/tb_calendar_ctr.sv
// Bench for calendar_ctr: two instances (28- and 29-day February) share stimulus
// and are compared each cycle against a day-counting reference model.
module tb_calendar_ctr;
  logic Clk = 1'b0, Reset_n = 1'b0, DayTick = 1'b0, SetMode = 1'b0;
  logic DateAdv = 1'b0, MonthAdv = 1'b0, DayAdv = 1'b0;

  logic [5:0] date_a, date_b;
  logic [4:0] month_a, month_b;
  logic [2:0] day_a, day_b;
  logic       mt_a, mt_b, yt_a, yt_b;

  calendar_ctr #(.FEB_DAYS(28)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .DayTick(DayTick), .SetMode(SetMode),
    .DateAdv(DateAdv), .MonthAdv(MonthAdv), .DayAdv(DayAdv),
    .date_out(date_a), .month_out(month_a), .day_out(day_a),
    .month_tick(mt_a), .year_tick(yt_a));

  calendar_ctr #(.FEB_DAYS(29)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .DayTick(DayTick), .SetMode(SetMode),
    .DateAdv(DateAdv), .MonthAdv(MonthAdv), .DayAdv(DayAdv),
    .date_out(date_b), .month_out(month_b), .day_out(day_b),
    .month_tick(mt_b), .year_tick(yt_b));

  always #5 Clk = ~Clk;

  int checks = 0, passed = 0;

  // Reference model state, index 0 = FEB 28 instance, 1 = FEB 29 instance.
  int md[2], mm[2], mw[2], mmt[2], myt[2];
  int feb[2] = '{28, 29};
  bit mprev_date, mprev_month, mprev_day;

  function automatic int last_of(input int m, input int f);
    if (m == 2) return f;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md[i] = 1; mm[i] = 1; mw[i] = 0; mmt[i] = 0; myt[i] = 0;
    end
    mprev_date = 0; mprev_month = 0; mprev_day = 0;
  endtask

  task automatic model_clk();
    bit e_date, e_month, e_day;
    e_date  = DateAdv  && !mprev_date;
    e_month = MonthAdv && !mprev_month;
    e_day   = DayAdv   && !mprev_day;
    mprev_date = DateAdv; mprev_month = MonthAdv; mprev_day = DayAdv;
    for (int i = 0; i < 2; i++) begin
      mmt[i] = 0; myt[i] = 0;
      if (SetMode) begin
        if (e_date) md[i] = (md[i] % last_of(mm[i], feb[i])) + 1;
        if (e_day)  mw[i] = (mw[i] + 1) % 7;
        if (e_month) begin
          mm[i] = (mm[i] % 12) + 1;
          if (md[i] > last_of(mm[i], feb[i])) md[i] = last_of(mm[i], feb[i]);
        end
      end else if (DayTick) begin
        mw[i] = (mw[i] + 1) % 7;
        md[i] = md[i] + 1;
        if (md[i] > last_of(mm[i], feb[i])) begin
          md[i]  = 1;
          mmt[i] = 1;
          if (mm[i] == 12) begin mm[i] = 1; myt[i] = 1; end
          else mm[i] = mm[i] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic check_state();
    chk("a.date",  32'(date_a),  32'(md[0]));
    chk("a.month", 32'(month_a), 32'(mm[0]));
    chk("a.day",   32'(day_a),   32'(mw[0]));
    chk("a.mtick", 32'(mt_a),    32'(mmt[0]));
    chk("a.ytick", 32'(yt_a),    32'(myt[0]));
    chk("b.date",  32'(date_b),  32'(md[1]));
    chk("b.month", 32'(month_b), 32'(mm[1]));
    chk("b.day",   32'(day_b),   32'(mw[1]));
    chk("b.mtick", 32'(mt_b),    32'(mmt[1]));
    chk("b.ytick", 32'(yt_b),    32'(myt[1]));
  endtask

  // One clock: drive on the falling edge, model at the rising edge, check 1 time unit later.
  task automatic step(input logic dt, input logic sm, input logic da,
                      input logic ma, input logic ya);
    @(negedge Clk);
    DayTick = dt; SetMode = sm; DateAdv = da; MonthAdv = ma; DayAdv = ya;
    @(posedge Clk);
    model_clk();
    #1;
    check_state();
  endtask

  // Set-mode press-and-release of one button: 0=date, 1=month, 2=day.
  task automatic press(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, which == 0, which == 1, which == 2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    DayTick = 0; SetMode = 0; DateAdv = 0; MonthAdv = 0; DayAdv = 0;
    #1;
    model_reset();
    check_state();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [5:0] d0;
    model_reset();
    #12;
    check_state();
    chk("rst.date", 32'(date_a), 32'd1);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Count, then reset asynchronously mid-cycle and count again.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("async.month", 32'(month_a), 32'd1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("3tick.date", 32'(date_a), 32'd4);
    chk("3tick.day",  32'(day_a),  32'd3);

    // Jan 31 / day 6 -> Feb 1 / day 0 with month_tick only.
    do_reset();
    press(2, 6);
    press(0, 30);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mcarry.month", 32'(month_a), 32'd2);
    chk("mcarry.date",  32'(date_a),  32'd1);
    chk("mcarry.day",   32'(day_a),   32'd0);
    chk("mcarry.mtick", 32'(mt_a),    32'd1);
    chk("mcarry.ytick", 32'(yt_a),    32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mcarry.mtick_drop", 32'(mt_a), 32'd0);

    // Feb 28: 28-day instance carries, 29-day instance goes to Feb 29 then Mar 1.
    press(0, 27);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("feb28.a_month", 32'(month_a), 32'd3);
    chk("feb28.a_mtick", 32'(mt_a),    32'd1);
    chk("feb29.b_date",  32'(date_b),  32'd29);
    chk("feb29.b_mtick", 32'(mt_b),    32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("feb29.b_month", 32'(month_b), 32'd3);
    chk("feb29.b_mtick", 32'(mt_b),    32'd1);

    // Dec 31 -> Jan 1 with both ticks.
    do_reset();
    press(1, 11);
    press(0, 30);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("year.month", 32'(month_a), 32'd1);
    chk("year.mtick", 32'(mt_a),    32'd1);
    chk("year.ytick", 32'(yt_a),    32'd1);

    // Jan 31 + MonthAdv clamps to end of February; DateAdv then wraps to 1.
    do_reset();
    press(0, 30);
    press(1, 1);
    chk("clamp.a_date", 32'(date_a), 32'd28);
    chk("clamp.b_date", 32'(date_b), 32'd29);
    press(0, 1);
    chk("wrap.a_date",  32'(date_a),  32'd1);
    chk("wrap.a_month", 32'(month_a), 32'd2);

    // Held button gives exactly one increment.
    d0 = date_a;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold.date", 32'(date_a), 32'(d0) + 32'd1);

    // Mode gating in both directions.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gate.set_date", 32'(date_a), 32'(d0) + 32'd1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, k[0], k[0], k[0]);
    chk("gate.run_month", 32'(month_a), 32'd2);

    // Randomized segments alternating modes, with simultaneous button edges.
    for (int s = 0; s < 60; s++) begin
      logic sm;
      sm = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 60; k++)
        step($urandom_range(0, 3) != 0, sm,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if (s % 20 == 19) do_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
